// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO controller: op bit positions, FSM encoding
// and a small decode helper.
package hilo_ctrl_pkg;

    // Bit positions inside the one-hot hl_op vector.
    localparam int HL_OP_MULT  = 0;
    localparam int HL_OP_MULTU = 1;
    localparam int HL_OP_DIV   = 2;
    localparam int HL_OP_DIVU  = 3;
    localparam int HL_OP_MTHI  = 4;
    localparam int HL_OP_MTLO  = 5;
    localparam int HL_OP_MFHI  = 6;
    localparam int HL_OP_MFLO  = 7;

    // Controller FSM states.
    typedef enum logic [1:0] {
        HL_IDLE      = 2'd0,
        HL_DIV_WAIT  = 2'd1,
        HL_DIV_DRAIN = 2'd2
    } hl_state_t;

    // True when exactly one op bit is set; anything else is treated as illegal.
    function automatic logic hl_op_is_onehot(input logic [7:0] op);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {31'd0, op[i]};
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Divider link between the HI/LO controller (master) and the external divider (slave).
//
// Handshake: div_in_valid is a single-cycle launch pulse; the divider samples
// div_op/divisor/dividend on the clock edge where it is high and must not be
// launched again until its result is consumed. The result transfers on any
// clock edge where div_out_valid and div_out_ready are both high; the divider
// holds div_result stable while div_out_valid is high and div_out_ready is low.
interface hilo_ctrl_if;
    logic [1:0]  div_op;         // [0] signed divide, [1] unsigned divide
    logic [31:0] divisor;
    logic [31:0] dividend;
    logic        div_in_valid;
    logic [63:0] div_result;     // {HI = remainder, LO = quotient}
    logic        div_out_valid;
    logic        div_out_ready;

    modport master (
        output div_op, divisor, dividend, div_in_valid, div_out_ready,
        input  div_result, div_out_valid
    );

    modport slave (
        input  div_op, divisor, dividend, div_in_valid, div_out_ready,
        output div_result, div_out_valid
    );
endinterface

// File: rtl/hilo_ctrl_mul.sv
// Single-cycle 32x32 -> 64 multiplier for MULT/MULTU.
module hilo_ctrl_mul (
    input  logic [1:0]  mul_op_i,     // {multu, mult}
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [63:0] product_o
);
    logic        signed_mode;
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // Sign-extend for MULT, zero-extend otherwise; the low 64 bits of the
    // 64x64 product are then the correct two's-complement result either way.
    always_comb begin
        signed_mode = mul_op_i[0] & ~mul_op_i[1];
        a_ext       = {{32{signed_mode & src1_i[31]}}, src1_i};
        b_ext       = {{32{signed_mode & src2_i[31]}}, src2_i};
        product_o   = a_ext * b_ext;
    end
endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: owns the HI/LO registers, performs MULT/MT/MF in the
// issue cycle and runs DIV/DIVU on the external divider, stalling EXE until
// the result returns and draining an in-flight divide after a flush.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_HI = 32'h0,
    parameter logic [31:0] RESET_LO = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [7:0]  hl_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        op_commit,
    input  logic        flush,
    output logic        op_done,
    output logic [31:0] mf_rdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output hl_state_t   dbg_state,
    hilo_ctrl_if.master div
);
    hl_state_t   state_q, state_d;
    logic [31:0] hi_q, lo_q;
    logic [1:0]  div_op_q;
    logic [31:0] divisor_q, dividend_q;

    logic        op_legal, is_mult, is_div, is_mthi, is_mtlo, is_mfhi, is_mflo;
    logic        issue, go_div;
    logic [63:0] product;

    // Controls produced by the output process.
    logic launch, out_ready, done_c;
    logic wr_prod, wr_div, wr_hi, wr_lo;

    // Op decode; an illegal (non one-hot) op enables nothing.
    assign op_legal = hl_op_is_onehot(hl_op);
    assign is_mult  = op_legal & (hl_op[HL_OP_MULT] | hl_op[HL_OP_MULTU]);
    assign is_div   = op_legal & (hl_op[HL_OP_DIV]  | hl_op[HL_OP_DIVU]);
    assign is_mthi  = op_legal & hl_op[HL_OP_MTHI];
    assign is_mtlo  = op_legal & hl_op[HL_OP_MTLO];
    assign is_mfhi  = op_legal & hl_op[HL_OP_MFHI];
    assign is_mflo  = op_legal & hl_op[HL_OP_MFLO];
    assign issue    = op_valid & ~flush & ~rst;
    assign go_div   = issue & is_div & op_commit;

    hilo_ctrl_mul u_mul (
        .mul_op_i  ({hl_op[HL_OP_MULTU], hl_op[HL_OP_MULT]}),
        .src1_i    (src1),
        .src2_i    (src2),
        .product_o (product)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HL_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: a flush while waiting leaves a divide in flight that
    // must still be consumed before the divider can be launched again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HL_IDLE: begin
                if (state_q == HL_IDLE && go_div) state_d = HL_DIV_WAIT;
            end
            HL_DIV_WAIT: begin
                if (div.div_out_valid) state_d = HL_IDLE;
                else if (flush)        state_d = HL_DIV_DRAIN;
            end
            HL_DIV_DRAIN: begin
                if (div.div_out_valid) state_d = HL_IDLE;
            end
            default: state_d = HL_IDLE;
        endcase
    end

    // Output logic: handshake, op_done and HI/LO write enables.
    always_comb begin
        launch    = 1'b0;
        out_ready = 1'b0;
        done_c    = 1'b0;
        wr_prod   = 1'b0;
        wr_div    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        if (!rst) begin
            case (state_q)
                HL_IDLE: begin
                    if (issue) begin
                        if (is_div && op_commit) begin
                            launch = 1'b1;
                        end else begin
                            done_c = 1'b1;
                            if (op_commit) begin
                                wr_prod = is_mult;
                                wr_hi   = is_mthi;
                                wr_lo   = is_mtlo;
                            end
                        end
                    end
                end
                HL_DIV_WAIT: begin
                    out_ready = 1'b1;
                    if (div.div_out_valid && !flush) begin
                        done_c = 1'b1;
                        wr_div = 1'b1;
                    end
                end
                HL_DIV_DRAIN: begin
                    out_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= RESET_HI;
            lo_q <= RESET_LO;
        end else if (wr_prod) begin
            {hi_q, lo_q} <= product;
        end else if (wr_div) begin
            {hi_q, lo_q} <= div.div_result;
        end else begin
            if (wr_hi) hi_q <= src1;
            if (wr_lo) lo_q <= src1;
        end
    end

    // Divider operands captured at launch and held for the whole divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_op_q   <= 2'b00;
            divisor_q  <= 32'h0;
            dividend_q <= 32'h0;
        end else if (launch) begin
            div_op_q   <= {hl_op[HL_OP_DIVU], hl_op[HL_OP_DIV]};
            divisor_q  <= src2;
            dividend_q <= src1;
        end
    end

    // In the launch cycle the divider sees the live operands; afterwards the held copy.
    assign div.div_in_valid  = launch;
    assign div.div_out_ready = out_ready;
    assign div.div_op        = launch ? {hl_op[HL_OP_DIVU], hl_op[HL_OP_DIV]} : div_op_q;
    assign div.divisor       = launch ? src2 : divisor_q;
    assign div.dividend      = launch ? src1 : dividend_q;

    assign op_done   = done_c;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;
    assign mf_rdata  = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'h0);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl; the bench plays the external divider.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MTHI  = 8'h10;
    localparam logic [7:0] OP_MTLO  = 8'h20;
    localparam logic [7:0] OP_MFHI  = 8'h40;
    localparam logic [7:0] OP_MFLO  = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [7:0]  hl_op;
    logic [31:0] src1, src2;
    logic        op_commit;
    logic        flush;
    logic        op_done;
    logic [31:0] mf_rdata, hi_out, lo_out;
    hl_state_t   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_ctrl_if div_bus ();

    hilo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .hl_op     (hl_op),
        .src1      (src1),
        .src2      (src2),
        .op_commit (op_commit),
        .flush     (flush),
        .op_done   (op_done),
        .mf_rdata  (mf_rdata),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .dbg_state (dbg_state),
        .div       (div_bus)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic commit);
        op_valid  = 1'b1;
        hl_op     = op;
        src1      = a;
        src2      = b;
        op_commit = commit;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; hl_op = 8'h0; src1 = 32'h0; src2 = 32'h0;
        op_commit = 1'b0; flush = 1'b0;
        div_bus.div_result = 64'h0; div_bus.div_out_valid = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_state", 64'(dbg_state), 64'(HL_IDLE));
        check("rst_hi", 64'(hi_out), 64'h0);
        check("rst_lo", 64'(lo_out), 64'h0);
        check("rst_done", 64'(op_done), 64'h0);
        check("rst_in_valid", 64'(div_bus.div_in_valid), 64'h0);
        check("rst_out_ready", 64'(div_bus.div_out_ready), 64'h0);
        check("rst_div_op", 64'(div_bus.div_op), 64'h0);
        check("rst_divisor", 64'(div_bus.divisor), 64'h0);
        check("rst_dividend", 64'(div_bus.dividend), 64'h0);
        rst = 1'b0;
        tick();

        // 1: signed multiply -2 * 3.
        set_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        #1 check("mult_done", 64'(op_done), 64'h1);
        tick();
        check("mult_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_out), 64'hFFFF_FFFA);

        // 2: unsigned multiply of the same operands, then MFHI/MFLO.
        set_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
        #1 check("multu_done", 64'(op_done), 64'h1);
        tick();
        check("multu_hi", 64'(hi_out), 64'h2);
        check("multu_lo", 64'(lo_out), 64'hFFFF_FFFA);
        set_op(OP_MFHI, 32'h0, 32'h0, 1'b1);
        #1 check("mfhi_data", 64'(mf_rdata), 64'h2);
        check("mfhi_done", 64'(op_done), 64'h1);
        set_op(OP_MFLO, 32'h0, 32'h0, 1'b1);
        #1 check("mflo_data", 64'(mf_rdata), 64'hFFFF_FFFA);
        tick();

        // 3: signed divide -7 / 2 with operands held through the wait.
        set_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        #1 check("div_launch", 64'(div_bus.div_in_valid), 64'h1);
        check("div_launch_done", 64'(op_done), 64'h0);
        check("div_op_signed", 64'(div_bus.div_op), 64'h1);
        check("div_launch_divisor", 64'(div_bus.divisor), 64'h2);
        check("div_launch_dividend", 64'(div_bus.dividend), 64'hFFFF_FFF9);
        tick();
        check("div_state_wait", 64'(dbg_state), 64'(HL_DIV_WAIT));
        src1 = 32'hDEAD_BEEF; src2 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("div_wait_in_valid", 64'(div_bus.div_in_valid), 64'h0);
            check("div_wait_done", 64'(op_done), 64'h0);
            check("div_wait_ready", 64'(div_bus.div_out_ready), 64'h1);
            check("div_wait_divisor", 64'(div_bus.divisor), 64'h2);
            check("div_wait_dividend", 64'(div_bus.dividend), 64'hFFFF_FFF9);
            tick();
        end
        div_bus.div_out_valid = 1'b1;
        div_bus.div_result    = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        #1 check("div_result_done", 64'(op_done), 64'h1);
        tick();
        div_bus.div_out_valid = 1'b0;
        op_valid = 1'b0;
        check("div_back_idle", 64'(dbg_state), 64'(HL_IDLE));
        check("div_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("div_lo", 64'(lo_out), 64'hFFFF_FFFD);

        // 4: unsigned divide flushed mid-wait, result drained, next mult stalls.
        set_op(OP_DIVU, 32'd100, 32'd7, 1'b1);
        #1 check("divu_op", 64'(div_bus.div_op), 64'h2);
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1 check("divu_flush_done", 64'(op_done), 64'h0);
        tick();
        flush = 1'b0;
        check("divu_state_drain", 64'(dbg_state), 64'(HL_DIV_DRAIN));
        set_op(OP_MULT, 32'd5, 32'd6, 1'b1);
        #1 check("drain_mult_done", 64'(op_done), 64'h0);
        check("drain_in_valid", 64'(div_bus.div_in_valid), 64'h0);
        check("drain_ready", 64'(div_bus.div_out_ready), 64'h1);
        tick();
        check("drain_still", 64'(dbg_state), 64'(HL_DIV_DRAIN));
        div_bus.div_out_valid = 1'b1;
        div_bus.div_result    = {32'd2, 32'd14};
        #1 check("drain_result_done", 64'(op_done), 64'h0);
        tick();
        div_bus.div_out_valid = 1'b0;
        check("drain_to_idle", 64'(dbg_state), 64'(HL_IDLE));
        check("drain_hi_kept", 64'(hi_out), 64'hFFFF_FFFF);
        check("drain_lo_kept", 64'(lo_out), 64'hFFFF_FFFD);
        #1 check("post_drain_mult_done", 64'(op_done), 64'h1);
        tick();
        op_valid = 1'b0;
        check("post_drain_hi", 64'(hi_out), 64'h0);
        check("post_drain_lo", 64'(lo_out), 64'd30);

        // 5: flush coincident with the divider result.
        set_op(OP_DIV, 32'd20, 32'd3, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        div_bus.div_out_valid = 1'b1;
        div_bus.div_result    = {32'd2, 32'd6};
        #1 check("coinc_done", 64'(op_done), 64'h0);
        tick();
        flush = 1'b0; div_bus.div_out_valid = 1'b0; op_valid = 1'b0;
        check("coinc_idle", 64'(dbg_state), 64'(HL_IDLE));
        check("coinc_hi", 64'(hi_out), 64'h0);
        check("coinc_lo", 64'(lo_out), 64'd30);

        // 6: uncommitted MTHI, committed MTLO, illegal op, flushed op, uncommitted DIV.
        set_op(OP_MTHI, 32'h1234, 32'h0, 1'b0);
        #1 check("mthi_nc_done", 64'(op_done), 64'h1);
        tick();
        check("mthi_nc_hi", 64'(hi_out), 64'h0);
        set_op(OP_MTLO, 32'hABCD, 32'h0, 1'b1);
        tick();
        check("mtlo_lo", 64'(lo_out), 64'hABCD);
        set_op(8'h03, 32'd7, 32'd7, 1'b1);
        #1 check("illegal_done", 64'(op_done), 64'h1);
        check("illegal_mf", 64'(mf_rdata), 64'h0);
        tick();
        check("illegal_hi", 64'(hi_out), 64'h0);
        check("illegal_lo", 64'(lo_out), 64'hABCD);
        set_op(OP_MULT, 32'd7, 32'd7, 1'b1);
        flush = 1'b1;
        #1 check("idle_flush_done", 64'(op_done), 64'h0);
        tick();
        flush = 1'b0;
        check("idle_flush_lo", 64'(lo_out), 64'hABCD);
        set_op(OP_DIV, 32'd9, 32'd3, 1'b0);
        #1 check("div_nc_in_valid", 64'(div_bus.div_in_valid), 64'h0);
        check("div_nc_done", 64'(op_done), 64'h1);
        tick();
        check("div_nc_idle", 64'(dbg_state), 64'(HL_IDLE));

        // Reset in the middle of a divide.
        set_op(OP_DIV, 32'd9, 32'd3, 1'b1);
        tick();
        check("rst_mid_wait", 64'(dbg_state), 64'(HL_DIV_WAIT));
        op_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid_state", 64'(dbg_state), 64'(HL_IDLE));
        check("rst_mid_hi", 64'(hi_out), 64'h0);
        check("rst_mid_lo", 64'(lo_out), 64'h0);
        check("rst_mid_ready", 64'(div_bus.div_out_ready), 64'h0);
        rst = 1'b0;
        tick();
        check("rst_after_ready", 64'(div_bus.div_out_ready), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
